// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform monitor.
//   DATA_W    : default sample width (unsigned, offset-binary)
//   MIDSCALE  : default crossing threshold
//   sample_t  : one sample word at the default width
//   wm_state_t: measurement FSM states
package waveform_pkg;

  localparam int DATA_W   = 10;
  localparam int MIDSCALE = 512;

  typedef logic [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    S_SYNC,
    S_ARMED,
    S_MEAS_HIGH,
    S_MEAS_LOW
  } wm_state_t;

endpackage

// File: rtl/hyst_comparator.sv
// Classifies one sample against a hysteresis band around MIDSCALE.
//   sample_i  : unsigned sample
//   is_high_o : sample >= MIDSCALE + HYST
//   is_low_o  : sample <  MIDSCALE - HYST
// Samples inside the band raise neither flag. Purely combinational.
module hyst_comparator #(
  parameter int DATA_W   = 10,
  parameter int MIDSCALE = 512,
  parameter int HYST     = 16
) (
  input  logic [DATA_W-1:0] sample_i,
  output logic              is_high_o,
  output logic              is_low_o
);

  localparam int HI_THR = MIDSCALE + HYST;
  localparam int LO_THR = MIDSCALE - HYST;

  // Compare in 32-bit signed space so thresholds outside the sample range behave.
  assign is_high_o = (int'(sample_i) >= HI_THR);
  assign is_low_o  = (int'(sample_i) <  LO_THR);

endmodule

// File: rtl/waveform_monitor.sv
// Measures a periodic waveform on the DAC sample bus: period (in valid
// samples) between rising midscale crossings, plus min/max over each cycle.
//   clk, reset    : clock, asynchronous active-high reset
//   sample_in     : sample bus, sample_valid qualifies it
//   period        : samples per cycle of the last completed measurement
//   vmin, vmax    : extremes over the last completed cycle
//   result_valid  : one-cycle pulse when period/vmin/vmax update
//   timeout       : one-cycle pulse when the counter saturates without a crossing
//   locked        : high while measuring (S_MEAS_HIGH / S_MEAS_LOW)
// A sample presented in cycle N is reflected on the outputs in cycle N+2.
module waveform_monitor
  import waveform_pkg::*;
#(
  parameter int DATA_W   = waveform_pkg::DATA_W,
  parameter int MIDSCALE = waveform_pkg::MIDSCALE,
  parameter int HYST     = 16,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  output logic [PERIOD_W-1:0] period,
  output logic [DATA_W-1:0]   vmin,
  output logic [DATA_W-1:0]   vmax,
  output logic                result_valid,
  output logic                timeout,
  output logic                locked
);

  // Saturation is detected one count early so a crossing on the limiting
  // sample still yields period = 2^PERIOD_W-1 without wrapping.
  localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

  function automatic logic cnt_at_limit(input logic [PERIOD_W-1:0] c);
    return (c == CNT_LAST);
  endfunction

  function automatic logic [DATA_W-1:0] smin(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_W-1:0]   s_q;
  logic                v_q;
  wm_state_t           state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   tmin_q, tmin_d;
  logic [DATA_W-1:0]   tmax_q, tmax_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [DATA_W-1:0]   vmin_q, vmin_d;
  logic [DATA_W-1:0]   vmax_q, vmax_d;
  logic                rv_q, rv_d;
  logic                to_q, to_d;
  logic                is_high, is_low;
  logic [DATA_W-1:0]   run_min, run_max;

  // Stage 1: input register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      v_q <= 1'b0;
    end else begin
      s_q <= sample_in;
      v_q <= sample_valid;
    end
  end

  hyst_comparator #(
    .DATA_W   (DATA_W),
    .MIDSCALE (MIDSCALE),
    .HYST     (HYST)
  ) u_cmp (
    .sample_i  (s_q),
    .is_high_o (is_high),
    .is_low_o  (is_low)
  );

  // Running extremes including the current sample.
  assign run_min = smin(tmin_q, s_q);
  assign run_max = smax(tmax_q, s_q);

  // Stage 2: FSM, counter, trackers and output registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmin_d  = tmin_q;
    tmax_d  = tmax_q;
    per_d   = per_q;
    vmin_d  = vmin_q;
    vmax_d  = vmax_q;
    rv_d    = 1'b0;
    to_d    = 1'b0;

    if (v_q) begin
      unique case (state_q)
        S_SYNC: begin
          if (is_low) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end
        end

        S_ARMED: begin
          if (is_high) begin
            state_d = S_MEAS_HIGH;
            cnt_d   = '0;
            tmin_d  = s_q;
            tmax_d  = s_q;
          end else if (cnt_at_limit(cnt_q)) begin
            state_d = S_SYNC;
            cnt_d   = '0;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        S_MEAS_HIGH: begin
          if (cnt_at_limit(cnt_q)) begin
            state_d = S_SYNC;
            cnt_d   = '0;
            to_d    = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            tmin_d = run_min;
            tmax_d = run_max;
            if (is_low) state_d = S_MEAS_LOW;
          end
        end

        S_MEAS_LOW: begin
          // A crossing takes priority over saturation on the same sample.
          if (is_high) begin
            state_d = S_MEAS_HIGH;
            per_d   = cnt_q + 1'b1;
            vmin_d  = run_min;
            vmax_d  = run_max;
            rv_d    = 1'b1;
            cnt_d   = '0;
            tmin_d  = s_q;
            tmax_d  = s_q;
          end else if (cnt_at_limit(cnt_q)) begin
            state_d = S_SYNC;
            cnt_d   = '0;
            to_d    = 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            tmin_d = run_min;
            tmax_d = run_max;
          end
        end

        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      tmin_q  <= '0;
      tmax_q  <= '0;
      per_q   <= '0;
      vmin_q  <= '0;
      vmax_q  <= '0;
      rv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmin_q  <= tmin_d;
      tmax_q  <= tmax_d;
      per_q   <= per_d;
      vmin_q  <= vmin_d;
      vmax_q  <= vmax_d;
      rv_q    <= rv_d;
      to_q    <= to_d;
    end
  end

  assign period       = per_q;
  assign vmin         = vmin_q;
  assign vmax         = vmax_q;
  assign result_valid = rv_q;
  assign timeout      = to_q;
  assign locked       = (state_q == S_MEAS_HIGH) || (state_q == S_MEAS_LOW);

endmodule
